// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, the per-instruction byte count and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  localparam int BYTES_PER_INSTR  = 4;
  localparam int CNT_W            = $clog2(BYTES_PER_INSTR);
  localparam int DEFAULT_RESET_PC = 0;

  // An instruction address is usable only when it is 4-byte aligned.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Left-shift register that builds a big-endian instruction word one byte at a time.
// The first byte loaded ends up in the most significant position after four loads.
module byte_assembler #(
  parameter int BYTE_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [BYTE_W-1:0]  din,
  output logic [INSTR_W-1:0] word
);

  // A clear wins over a load so a byte returning from a stale read is never kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      word <= {word[INSTR_W-BYTE_W-1:0], din};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads four bytes per instruction from a 1-cycle byte memory,
// assembles a big-endian word and hands it to decode with a valid/ready handshake.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                BYTE_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [BYTE_W-1:0]  mem_rd_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               misalign_err
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              cap_pending;
  logic              redirect_ok;
  logic              redirect_bad;
  logic              accept;

  assign redirect_ok  = redirect_valid &&  is_aligned(redirect_pc[1:0]);
  assign redirect_bad = redirect_valid && !is_aligned(redirect_pc[1:0]);
  assign accept       = (state == HOLD) && instr_ready;

  assign mem_rd_en   = (state == FETCH);
  assign mem_addr    = mem_rd_en ? (pc + ADDR_W'(cnt)) : '0;
  assign instr_valid = (state == HOLD);

  // Next-state logic; an aligned redirect overrides whatever the current state wanted.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cnt;

    case (state)
      IDLE: begin
        if (fetch_en) begin
          state_next = FETCH;
          cnt_next   = '0;
        end
      end
      FETCH: begin
        if (cnt == CNT_W'(BYTES_PER_INSTR - 1)) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DRAIN: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (accept) begin
          pc_next    = pc + ADDR_W'(BYTES_PER_INSTR);
          state_next = fetch_en ? FETCH : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (redirect_ok) begin
      pc_next    = redirect_pc;
      cnt_next   = '0;
      state_next = fetch_en ? FETCH : IDLE;
    end
  end

  // State, PC and byte counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cnt   <= cnt_next;
    end
  end

  // A read issued this cycle returns next cycle; a redirect cancels that return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pending <= 1'b0;
    end else begin
      cap_pending <= (state == FETCH) && !redirect_ok;
    end
  end

  // instr_pc is latched as the word completes so it stays put while decode stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_pc     <= '0;
      misalign_err <= 1'b0;
    end else begin
      if ((state == DRAIN) && !redirect_ok) begin
        instr_pc <= pc;
      end
      misalign_err <= redirect_bad;
    end
  end

  byte_assembler #(
    .BYTE_W  (BYTE_W),
    .INSTR_W (INSTR_W)
  ) u_byte_assembler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect_ok),
    .load  (cap_pending),
    .din   (mem_rd_data),
    .word  (instr)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a 1-cycle byte memory model.
// Expected words come from the memory contents read in big-endian order at the model PC.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 10;
  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               fetch_en = 1'b0;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BYTE_W-1:0]  mem_rd_data = '0;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               misalign_err;

  logic [7:0] mem [0:1023];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  function automatic logic [31:0] ref_word(input logic [9:0] pc);
    return {mem[pc], mem[pc + 10'd1], mem[pc + 10'd2], mem[pc + 10'd3]};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [54:0] outs;
    rst_n = 1'b0;
    @(negedge clk);
    outs = {mem_rd_en, mem_addr, instr_valid, instr, instr_pc, misalign_err};
    checks++;
    if (outs !== 55'd0) $display("[TB] FAIL reset_outputs: got %h, expected 0", outs);
    else passes++;
    apply_reset();
    @(negedge clk);
    checks++;
    if ({mem_rd_en, instr_valid} !== 2'b00)
      $display("[TB] FAIL idle_quiet: got %b, expected 00", {mem_rd_en, instr_valid});
    else passes++;
  endtask

  task automatic test_first_fetch();
    bit ok;
    int t0;
    logic [9:0] ea;
    apply_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_rd(ok);
    t0 = cyc;
    checks++;
    if (!ok) $display("[TB] FAIL first_rd: got timeout, expected mem_rd_en"); else passes++;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      ea = 10'(k);
      checks++;
      if ({mem_rd_en, mem_addr} !== {1'b1, ea})
        $display("[TB] FAIL first_addr%0d: got %b/%h, expected 1/%h", k, mem_rd_en, mem_addr, ea);
      else passes++;
    end
    wait_valid(ok);
    checks++;
    if (!ok || (cyc - t0) != 5)
      $display("[TB] FAIL first_latency: got %0d, expected 5", cyc - t0);
    else passes++;
    checks++;
    if (instr !== ref_word(10'd0) || instr_pc !== 10'd0)
      $display("[TB] FAIL first_word: got %h@%h, expected %h@000", instr, instr_pc, ref_word(10'd0));
    else passes++;
    wait_rd(ok);
    checks++;
    if (!ok || (cyc - t0) != 6 || mem_addr !== 10'd4)
      $display("[TB] FAIL throughput: got %0d cycles addr %h, expected 6 cycles addr 004", cyc - t0, mem_addr);
    else passes++;
  endtask

  task automatic test_stall();
    bit ok;
    apply_reset();
    fetch_en = 1'b1; instr_ready = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok) $display("[TB] FAIL stall_valid: got timeout, expected instr_valid"); else passes++;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({instr_valid, mem_rd_en, instr, instr_pc} !== {1'b1, 1'b0, ref_word(10'd0), 10'd0})
        $display("[TB] FAIL stall_hold%0d: got v%b rd%b %h@%h, expected v1 rd0 %h@000",
                 i, instr_valid, mem_rd_en, instr, instr_pc, ref_word(10'd0));
      else passes++;
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'd4})
      $display("[TB] FAIL stall_next_addr: got %b/%h, expected 1/004", mem_rd_en, mem_addr);
    else passes++;
    wait_valid(ok);
    checks++;
    if (!ok || instr !== ref_word(10'd4) || instr !== 32'h0 || instr_pc !== 10'd4)
      $display("[TB] FAIL stall_next_word: got %h@%h, expected 00000000@004", instr, instr_pc);
    else passes++;
  endtask

  task automatic test_redirect();
    bit ok;
    int t0;
    apply_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_rd(ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || mem_addr !== 10'd2) $display("[TB] FAIL redir_pre: got %h, expected 002", mem_addr);
    else passes++;
    redirect_valid = 1'b1; redirect_pc = 10'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    t0 = cyc;
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'h100})
      $display("[TB] FAIL redir_addr: got %b/%h, expected 1/100", mem_rd_en, mem_addr);
    else passes++;
    wait_valid(ok);
    checks++;
    if (!ok || (cyc - t0) != 5 || instr_pc !== 10'h100 || instr !== ref_word(10'h100))
      $display("[TB] FAIL redir_word: got %h@%h after %0d, expected %h@100 after 5",
               instr, instr_pc, cyc - t0, ref_word(10'h100));
    else passes++;
  endtask

  task automatic test_misalign();
    bit ok;
    apply_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_rd(ok);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 10'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (!ok || {misalign_err, mem_rd_en, mem_addr} !== {1'b1, 1'b1, 10'd2})
      $display("[TB] FAIL misalign_pulse: got err%b addr %h, expected err1 addr 002", misalign_err, mem_addr);
    else passes++;
    @(negedge clk);
    checks++;
    if ({misalign_err, mem_addr} !== {1'b0, 10'd3})
      $display("[TB] FAIL misalign_end: got err%b addr %h, expected err0 addr 003", misalign_err, mem_addr);
    else passes++;
    wait_valid(ok);
    checks++;
    if (!ok || instr_pc !== 10'd0 || instr !== ref_word(10'd0))
      $display("[TB] FAIL misalign_word: got %h@%h, expected %h@000", instr, instr_pc, ref_word(10'd0));
    else passes++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [9:0] ea;
    apply_reset();
    redirect_valid = 1'b1; redirect_pc = 10'h3FC; fetch_en = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      ea = 10'h3FC + 10'(k);
      checks++;
      if ({mem_rd_en, mem_addr} !== {1'b1, ea})
        $display("[TB] FAIL wrap_addr%0d: got %b/%h, expected 1/%h", k, mem_rd_en, mem_addr, ea);
      else passes++;
    end
    wait_valid(ok);
    checks++;
    if (!ok || instr_pc !== 10'h3FC || instr !== ref_word(10'h3FC))
      $display("[TB] FAIL wrap_word: got %h@%h, expected %h@3fc", instr, instr_pc, ref_word(10'h3FC));
    else passes++;
    wait_rd(ok);
    checks++;
    if (!ok || mem_addr !== 10'd0 || misalign_err !== 1'b0)
      $display("[TB] FAIL wrap_next: got addr %h err%b, expected addr 000 err0", mem_addr, misalign_err);
    else passes++;
  endtask

  task automatic test_reset_midfetch();
    bit ok;
    logic [54:0] outs;
    apply_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_rd(ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {mem_rd_en, mem_addr, instr_valid, instr, instr_pc, misalign_err};
    checks++;
    if (!ok || outs !== 55'd0) $display("[TB] FAIL midreset_outputs: got %h, expected 0", outs);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_rd(ok);
    checks++;
    if (!ok || mem_addr !== 10'd0) $display("[TB] FAIL midreset_restart: got %h, expected 000", mem_addr);
    else passes++;
    wait_valid(ok);
    checks++;
    if (!ok || instr !== ref_word(10'd0) || instr_pc !== 10'd0)
      $display("[TB] FAIL midreset_word: got %h@%h, expected %h@000", instr, instr_pc, ref_word(10'd0));
    else passes++;
  endtask

  task automatic test_fetch_en_drop();
    bit ok;
    bit seen_rd;
    apply_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_rd(ok);
    @(negedge clk);
    fetch_en = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok || instr !== ref_word(10'd0) || instr_pc !== 10'd0)
      $display("[TB] FAIL drop_complete: got %h@%h, expected %h@000", instr, instr_pc, ref_word(10'd0));
    else passes++;
    seen_rd = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1 || instr_valid === 1'b1) seen_rd = 1'b1;
    end
    checks++;
    if (seen_rd !== 1'b0) $display("[TB] FAIL drop_idle: got activity 1, expected 0");
    else passes++;
  endtask

  task automatic test_random();
    logic [9:0] exp_pc;
    logic [9:0] tgt;
    bit exp_mis;
    int accepts;
    apply_reset();
    fetch_en = 1'b1;
    exp_pc = 10'd0;
    exp_mis = 1'b0;
    accepts = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (misalign_err !== exp_mis)
        $display("[TB] FAIL rnd_misalign%0d: got %b, expected %b", i, misalign_err, exp_mis);
      else passes++;
      checks++;
      if (mem_rd_en === 1'b1 && instr_valid === 1'b1)
        $display("[TB] FAIL rnd_rd_in_hold%0d: got rd_en 1, expected 0", i);
      else passes++;
      redirect_valid = 1'b0;
      exp_mis = 1'b0;
      instr_ready = ($urandom_range(0, 3) != 0);
      fetch_en = ($urandom_range(0, 15) != 0);
      if (instr_valid === 1'b1 && instr_ready) begin
        checks++;
        if (instr !== ref_word(exp_pc) || instr_pc !== exp_pc)
          $display("[TB] FAIL rnd_word%0d: got %h@%h, expected %h@%h", i, instr, instr_pc, ref_word(exp_pc), exp_pc);
        else passes++;
        exp_pc = exp_pc + 10'd4;
        accepts++;
      end
      if ($urandom_range(0, 11) == 0) begin
        tgt = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        if (tgt[1:0] == 2'b00) exp_pc = tgt;
        else exp_mis = 1'b1;
      end
    end
    redirect_valid = 1'b0;
    checks++;
    if (accepts < 10) $display("[TB] FAIL rnd_progress: got %0d accepts, expected at least 10", accepts);
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h4D; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    for (int i = 4; i < 8; i++) mem[i] = 8'h00;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_misalign();
    test_wrap();
    test_reset_midfetch();
    test_fetch_en_drop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
